// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts one RISC-V instruction,
// drives the ALU for one cycle, then returns the write-back/branch result.
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   output logic [4:0]  Upr_ALU,
   output logic [31:0] A,
   output logic [31:0] B,
   input  logic        C,
   input  logic [31:0] Out_ALU,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_en,
   output logic        branch_taken,
   output logic [31:0] br_offset,
   output logic        illegal
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never waits on ready, and ready/valid here depend on state only.

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_B   = 7'b1100011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd_field;
   logic [31:0] shamt_ext;
   logic [31:0] imm_i_ext;
   logic [31:0] imm_b_ext;

   logic [4:0]  dec_code;
   logic [31:0] dec_b;
   logic [31:0] dec_off;
   logic        dec_legal;
   logic        dec_branch;
   logic        dec_writes;

   logic        pend_branch;
   logic        pend_wr;

   logic        unused_rs1_field;

   assign opcode    = instr[6:0];
   assign funct7    = instr[31:25];
   assign funct3    = instr[14:12];
   assign rd_field  = instr[11:7];
   assign shamt_ext = {27'd0, instr[24:20]};
   assign imm_i_ext = {{20{instr[31]}}, instr[31:20]};
   assign imm_b_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};

   // The register indices were already consumed by the register-file stage.
   assign unused_rs1_field = ^instr[19:15];

   always_comb begin
      dec_code   = 5'd0;
      dec_b      = rs2_val;
      dec_off    = 32'd0;
      dec_legal  = 1'b0;
      dec_branch = 1'b0;
      dec_writes = 1'b0;
      case (opcode)
         OPC_R: begin
            dec_code   = {1'b0, instr[30], funct3};
            dec_b      = rs2_val;
            dec_writes = 1'b1;
            dec_legal  = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) &&
                          ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_I: begin
            dec_code   = {2'b00, funct3};
            dec_b      = imm_i_ext;
            dec_writes = 1'b1;
            dec_legal  = 1'b1;
            if (funct3 == 3'b001) begin
               dec_b     = shamt_ext;
               dec_legal = (funct7 == F7_BASE);
            end else if (funct3 == 3'b101) begin
               // instr[30] selects SRAI vs SRLI, mirroring the R-type encoding.
               dec_b     = shamt_ext;
               dec_code  = {1'b0, instr[30], 3'b101};
               dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end
         end
         OPC_B: begin
            dec_code   = {2'b11, funct3};
            dec_b      = rs2_val;
            dec_branch = 1'b1;
            dec_off    = imm_b_ext;
            dec_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) begin
               state_next = dec_legal ? EXEC : RESP;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         Upr_ALU      <= 5'd0;
         A            <= 32'd0;
         B            <= 32'd0;
         wb_data      <= 32'd0;
         wb_rd        <= 5'd0;
         wb_en        <= 1'b0;
         branch_taken <= 1'b0;
         br_offset    <= 32'd0;
         illegal      <= 1'b0;
         pend_branch  <= 1'b0;
         pend_wr      <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  wb_rd   <= rd_field;
                  illegal <= !dec_legal;
                  if (dec_legal) begin
                     Upr_ALU     <= dec_code;
                     A           <= rs1_val;
                     B           <= dec_b;
                     br_offset   <= dec_off;
                     pend_branch <= dec_branch;
                     pend_wr     <= dec_writes && (rd_field != 5'd0);
                  end else begin
                     // Illegal goes straight to RESP; the ALU operands keep their old values.
                     br_offset    <= 32'd0;
                     wb_en        <= 1'b0;
                     branch_taken <= 1'b0;
                  end
               end
            end
            EXEC: begin
               wb_data      <= Out_ALU;
               branch_taken <= pend_branch && C;
               wb_en        <= pend_wr;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: acts as the ALU, drives directed instructions and
// checks every cycle against an instruction-level model.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  Upr_ALU;
   logic [31:0] A;
   logic [31:0] B;
   logic        C;
   logic [31:0] Out_ALU;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_en;
   logic        branch_taken;
   logic [31:0] br_offset;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .Upr_ALU(Upr_ALU), .A(A), .B(B), .C(C), .Out_ALU(Out_ALU),
      .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_en(wb_en), .branch_taken(branch_taken),
      .br_offset(br_offset), .illegal(illegal)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------- combinational ALU seen by the DUT ----------------
   always_comb begin
      Out_ALU = 32'd0;
      C       = 1'b0;
      case (Upr_ALU)
         5'b00000: Out_ALU = A + B;
         5'b01000: Out_ALU = A - B;
         5'b00001: Out_ALU = A << B[4:0];
         5'b00010: Out_ALU = {31'd0, ($signed(A) < $signed(B))};
         5'b00011: Out_ALU = {31'd0, (A < B)};
         5'b00100: Out_ALU = A ^ B;
         5'b00101: Out_ALU = A >> B[4:0];
         5'b01101: Out_ALU = 32'($signed(A) >>> B[4:0]);
         5'b00110: Out_ALU = A | B;
         5'b00111: Out_ALU = A & B;
         5'b11000: C = (A == B);
         5'b11001: C = (A != B);
         5'b11100: C = ($signed(A) < $signed(B));
         5'b11101: C = ($signed(A) >= $signed(B));
         5'b11110: C = (A < B);
         5'b11111: C = (A >= B);
         default:  Out_ALU = 32'd0;
      endcase
      if (Upr_ALU[4:3] == 2'b11) Out_ALU = {31'd0, C};
   end

   // ---------------- instruction-level model ----------------
   typedef struct packed {
      logic        ill;
      logic [4:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wen;
      logic        taken;
      logic [31:0] off;
   } exp_t;

   // Operation index: 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and
   // 10 beq 11 bne 12 blt 13 bge 14 bltu 15 bgeu
   localparam logic [4:0] CODE_TAB [16] = '{
      5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01101,
      5'b00110, 5'b00111, 5'b11000, 5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b11111};
   localparam int F3_OP [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

   function automatic exp_t model(input logic [31:0] i, input logic [31:0] r1,
                                  input logic [31:0] r2);
      exp_t        e;
      int          op;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] opb;
      logic        cmp;
      e   = '0;
      f7  = i[31:25];
      f3  = i[14:12];
      op  = -1;
      opb = r2;
      cmp = 1'b0;
      e.rd = i[11:7];
      case (i[6:0])
         7'b0110011: begin
            if (f7 == 7'h00) op = F3_OP[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
         end
         7'b0010011: begin
            opb = {{20{i[31]}}, i[31:20]};
            if (f3 == 3'd1 || f3 == 3'd5) begin
               opb = {27'd0, i[24:20]};
               if (f7 == 7'h00) op = F3_OP[f3];
               else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
            end else begin
               op = F3_OP[f3];
            end
         end
         7'b1100011: begin
            if (f3 < 3'd2) op = 10 + int'(f3);
            else if (f3 > 3'd3) op = 8 + int'(f3);
         end
         default: op = -1;
      endcase
      if (op < 0) begin
         e.ill = 1'b1;
         return e;
      end
      e.code = CODE_TAB[op];
      e.a    = r1;
      e.b    = opb;
      case (op)
         0:  e.data = r1 + opb;
         1:  e.data = r1 - opb;
         2:  e.data = r1 << opb[4:0];
         3:  e.data = ($signed(r1) < $signed(opb)) ? 32'd1 : 32'd0;
         4:  e.data = (r1 < opb) ? 32'd1 : 32'd0;
         5:  e.data = r1 ^ opb;
         6:  e.data = r1 >> opb[4:0];
         7:  e.data = 32'($signed(r1) >>> opb[4:0]);
         8:  e.data = r1 | opb;
         9:  e.data = r1 & opb;
         10: cmp = (r1 == opb);
         11: cmp = (r1 != opb);
         12: cmp = ($signed(r1) < $signed(opb));
         13: cmp = ($signed(r1) >= $signed(opb));
         14: cmp = (r1 < opb);
         default: cmp = (r1 >= opb);
      endcase
      if (op >= 10) begin
         e.data  = {31'd0, cmp};
         e.taken = cmp;
         e.off   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end else begin
         e.wen = (i[11:7] != 5'd0);
      end
      return e;
   endfunction

   // Model timeline: 0 waiting for an instruction, 1 ALU cycle, 2 response held.
   int          m_phase = 0;
   logic        m_fresh = 1'b1;
   logic        started = 1'b0;
   exp_t        m_cur   = '0;
   logic [4:0]  m_code  = 5'd0;
   logic [31:0] m_a     = 32'd0;
   logic [31:0] m_b     = 32'd0;

   always @(posedge clk) begin
      started <= 1'b1;
      if (rst) begin
         m_phase <= 0;
         m_fresh <= 1'b1;
         m_cur   <= '0;
         m_code  <= 5'd0;
         m_a     <= 32'd0;
         m_b     <= 32'd0;
      end else if (m_phase == 0) begin
         if (in_valid) begin
            exp_t e;
            e = model(instr, rs1_val, rs2_val);
            m_cur   <= e;
            m_fresh <= 1'b0;
            if (e.ill) begin
               m_phase <= 2;
            end else begin
               m_phase <= 1;
               m_code  <= e.code;
               m_a     <= e.a;
               m_b     <= e.b;
            end
         end
      end else if (m_phase == 1) begin
         m_phase <= 2;
      end else if (out_ready) begin
         m_phase <= 0;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk1("in_ready", in_ready, (m_phase == 0) && !rst);
         chk1("out_valid", out_valid, m_phase == 2);
         chk32("Upr_ALU", 32'(Upr_ALU), 32'(m_code));
         chk32("A", A, m_a);
         chk32("B", B, m_b);
         if (m_phase == 2 || m_fresh) begin
            chk32("wb_rd", 32'(wb_rd), 32'(m_cur.rd));
            chk1("wb_en", wb_en, m_cur.wen);
            chk1("branch_taken", branch_taken, m_cur.taken);
            chk32("br_offset", br_offset, m_cur.off);
            chk1("illegal", illegal, m_cur.ill);
            if (!m_cur.ill) chk32("wb_data", wb_data, m_cur.data);
         end
      end
   end

   // ---------------- driver ----------------
   logic [4:0]  s_code;
   logic [31:0] s_a, s_b, s_data, s_off;
   logic [4:0]  s_rd;
   logic        s_wen, s_taken, s_ill;
   int          s_lat;

   task automatic issue(input logic [31:0] i, input logic [31:0] r1,
                        input logic [31:0] r2, input int hold);
      int t;
      instr = i; rs1_val = r1; rs2_val = r2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
      s_code = Upr_ALU; s_a = A; s_b = B;
      t = 0;
      while (!out_valid && t < 8) begin
         @(posedge clk); #1;
         t++;
      end
      s_lat = t;
      if (!out_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: out_valid=0 after %0d cycles, required 1", t);
      end
      s_data = wb_data; s_rd = wb_rd; s_wen = wb_en;
      s_taken = branch_taken; s_off = br_offset; s_ill = illegal;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   localparam logic [31:0] MIX_INSTR [14] = '{
      32'h4020D1B3, 32'h0020B233, 32'h0020A233, 32'h01F09393, 32'hFFF0C093,
      32'h0F00E113, 32'hFFF0A113, 32'hFFF0B113, 32'h0020E463, 32'h0020F463,
      32'h0020C463, 32'h0020D463, 32'h401091B3, 32'h41F09393};

   initial begin
      rst = 1'b1; in_valid = 1'b0; instr = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk1("post_rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      issue(32'h002081B3, 32'd5, 32'd7, 0);
      chk32("add_code", 32'(s_code), 32'h00);
      chk32("add_a", s_a, 32'd5);
      chk32("add_b", s_b, 32'd7);
      chk32("add_lat", 32'(s_lat), 32'd1);
      chk32("add_data", s_data, 32'd12);
      chk32("add_rd", 32'(s_rd), 32'd3);
      chk1("add_wen", s_wen, 1'b1);

      issue(32'hFFF00293, 32'd0, 32'd123, 0);
      chk32("addi_b", s_b, 32'hFFFFFFFF);
      chk32("addi_code", 32'(s_code), 32'h00);
      chk32("addi_data", s_data, 32'hFFFFFFFF);

      issue(32'h4040D313, 32'h80000000, 32'd0, 0);
      chk32("srai_code", 32'(s_code), 32'h0D);
      chk32("srai_b", s_b, 32'd4);
      chk32("srai_data", s_data, 32'hF8000000);
      chk32("srai_rd", 32'(s_rd), 32'd6);

      issue(32'h00100013, 32'd0, 32'd0, 0);
      chk1("addi_x0_wen", s_wen, 1'b0);

      issue(32'h00208463, 32'd9, 32'd9, 0);
      chk32("beq_code", 32'(s_code), 32'h18);
      chk1("beq_taken", s_taken, 1'b1);
      chk32("beq_off", s_off, 32'd8);
      chk1("beq_wen", s_wen, 1'b0);

      issue(32'h00208463, 32'd9, 32'd10, 0);
      chk1("beq_not_taken", s_taken, 1'b0);

      issue(32'hFE209EE3, 32'd3, 32'd4, 0);
      chk32("bne_off", s_off, 32'hFFFFFFFC);
      chk1("bne_taken", s_taken, 1'b1);

      issue(32'h00012083, 32'd1, 32'd2, 0);
      chk32("ill_lat", 32'(s_lat), 32'd0);
      chk1("ill_flag", s_ill, 1'b1);
      chk1("ill_wen", s_wen, 1'b0);
      chk32("ill_code_kept", 32'(s_code), 32'h19);

      issue(32'h0020A463, 32'd1, 32'd2, 0);
      chk1("br_f3_010_ill", s_ill, 1'b1);

      // Backpressure: response held for five cycles before the consumer takes it.
      issue(32'h40208133, 32'd20, 32'd50, 5);
      chk32("sub_data", s_data, 32'hFFFFFFE2);
      chk1("sub_ill", s_ill, 1'b0);

      foreach (MIX_INSTR[k]) begin
         issue(MIX_INSTR[k], $urandom, $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom,
               $urandom_range(0, 2));
      end

      // Reset while the ALU cycle is in progress drops the instruction.
      instr = 32'h002081B3; rs1_val = 32'd1; rs2_val = 32'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk1("rst_exec_no_out_valid", out_valid, 1'b0);
         @(posedge clk); #1;
      end

      // Reset while the response is being held also drops it.
      instr = 32'h00208463; rs1_val = 32'd5; rs2_val = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk1("resp_before_rst", out_valid, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk1("rst_resp_dropped", out_valid, 1'b0);
      chk32("rst_resp_code", 32'(Upr_ALU), 32'h00);
      @(posedge clk); #1;

      issue(32'h002081B3, 32'd100, 32'd23, 0);
      chk32("post_rst_add_data", s_data, 32'd123);
      chk32("post_rst_add_lat", 32'(s_lat), 32'd1);

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller driving the processor's combinational ALU from the opposite side of its control interface. It accepts one RISC-V instruction with its source-register values over a valid/ready handshake, decodes it into the 5-bit ALU control code and operand pair, and presents them to the ALU for one cycle. It then captures `Out_ALU`/`C` and returns a write-back or branch result over a second valid/ready handshake. It sits between the register-file read stage and write-back.

## Interface
- No parameters; data width fixed at 32, ALU control width fixed at 5.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: instruction and operands valid.
- `in_ready` out 1: controller can accept; 1 only in IDLE with `rst` low.
- `instr` in 32: RISC-V instruction word.
- `rs1_val`, `rs2_val` in 32 each: source register values.
- `Upr_ALU` out 5: ALU control code, registered.
- `A`, `B` out 32 each: ALU operands, registered.
- `C` in 1: ALU comparison flag.
- `Out_ALU` in 32: ALU result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `wb_data` out 32: captured `Out_ALU`.
- `wb_rd` out 5: destination register, `instr[11:7]`.
- `wb_en` out 1: register write enable.
- `branch_taken` out 1: captured `C` for branches, else 0.
- `br_offset` out 32: sign-extended B-type immediate, else 0.
- `illegal` out 1: unsupported instruction.

## Operation
- ALU codes:
  - ADD 00000, SUB 01000, SLL 00001, SLTS 00010, SLTU 00011, XOR 00100.
  - SRL 00101, SRA 01101, OR 00110, AND 00111.
  - EQ 11000, NE 11001, LTS 11100, GES 11101, LTU 11110, GEU 11111.
- Decode on `instr[6:0]`:
  - 0110011 (R): code `{1'b0, instr[30], funct3}`; B = `rs2_val`.
    - Legal only if `instr[31:25]` is 0000000.
    - Or 0100000 with funct3 000 or 101.
  - 0010011 (I): B = sign-extended `instr[31:20]`; code `{1'b0, 1'b0, funct3}`.
    - For funct3 001: B = `{27'b0, instr[24:20]}`; requires `instr[31:25]` = 0000000.
    - For funct3 101: B = `{27'b0, instr[24:20]}`; code `{1'b0, instr[30], 3'b101}`; requires `instr[31:25]` = 0000000 or 0100000.
  - 1100011 (B): code `{2'b11, funct3}`; B = `rs2_val`; funct3 010/011 illegal.
    - `br_offset` = sign-extended `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`.
  - Any other opcode or failed check: illegal.
- A = `rs1_val` for all legal instructions.
- FSM states IDLE, EXEC, RESP:
  - IDLE: `in_ready`=1. If `in_valid`, decode into operand registers.
    - Legal: go to EXEC.
    - Illegal: go to RESP with `illegal`=1, `wb_en`=0, `branch_taken`=0; `Upr_ALU`/`A`/`B` not updated.
  - EXEC (one cycle): `Upr_ALU`/`A`/`B` stable. At the end edge capture the response and go to RESP:
    - `wb_data` = `Out_ALU`.
    - `branch_taken` = `C` (branches only).
    - `wb_en` = 1 for R/I types with `wb_rd` ≠ 0, else 0.
  - RESP: `out_valid`=1; all result outputs held stable. Go to IDLE on `out_ready`=1.
- `Upr_ALU`/`A`/`B` retain their last values outside EXEC.
- Reset:
  - State goes to IDLE.
  - These outputs clear to 0: `Upr_ALU`, `A`, `B`, `out_valid`, `wb_data`, `wb_rd`, `wb_en`, `branch_taken`, `br_offset`, `illegal`.
  - Reset from any state, including EXEC and RESP, discards the in-flight instruction; no `out_valid` results.

## Timing
- Accept edge k (`in_valid`&&`in_ready`) → EXEC during cycle k+1 → `out_valid` high from cycle k+2.
- Illegal: `out_valid` high from cycle k+1.
- Minimum issue interval 3 cycles for legal instructions, 2 for illegal.
- `in_ready` is 0 in EXEC and RESP; there is no overlap of accept and respond.
- `out_valid` stays high until the handshake completes, for any number of cycles.
- `in_ready` is combinational from state and `rst` only; there is no combinational path from `in_valid` or `out_ready` to any output.
- `Out_ALU` and `C` are sampled only at the end of EXEC.

## Test plan
- Reset → `in_ready`=0 during `rst`, then 1. All other outputs are 0.
- ADD:
  - Stimulus: `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, ALU model.
  - EXEC: `Upr_ALU`=00000, A=5, B=7.
  - Cycle k+2: `out_valid`=1, `wb_data`=12, `wb_rd`=3, `wb_en`=1.
- I-type:
  - `addi x5,x0,-1` (0xFFF00293) → B=0xFFFFFFFF, `Upr_ALU`=00000.
  - `srai x6,x1,4` (0x4040D313) → `Upr_ALU`=01101, B=4, `wb_data` = model `Out_ALU`.
  - `addi x0,x0,1` → `wb_en`=0.
- Branch:
  - `beq x1,x2,+8` (0x00208463), rs1=rs2=9 → `Upr_ALU`=11000.
  - Result: `branch_taken`=1, `br_offset`=8, `wb_en`=0.
  - Repeat with rs2=10 → `branch_taken`=0.
- Illegal opcode 0000011 → `out_valid` at k+1, `illegal`=1, `wb_en`=0; `Upr_ALU` unchanged.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles in RESP → outputs stable, `in_ready`=0.
  - Then `out_ready`=1 → IDLE next cycle.
  - Assert `rst` during EXEC → no `out_valid`; the next instruction completes normally.
